countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 66 ++++++
 tb/tb_countdown_timer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: prescaled down-counter with one-shot/periodic expiry, load and reload register.
module countdown_timer #(
    parameter int W            = 4,
    parameter int DEFAULT_LOAD = 9,
    parameter int PRESCALE     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         auto_reload,
    output logic [W-1:0] count,
    output logic         stop,
    output logic         expired,
    output logic         running
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    typedef enum logic {RUN, DONE} state_t;
    state_t         state_q;
    logic [W-1:0]   count_q, reload_q;
    logic [PW-1:0]  pcnt_q;
    logic           stop_q, expired_q;
    logic           adv, tick;
    assign adv  = state_q == RUN && en;
    assign tick = adv && pcnt_q == PW'(PRESCALE - 1);
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= RUN;
            count_q   <= W'(DEFAULT_LOAD);
            reload_q  <= W'(DEFAULT_LOAD);
            pcnt_q    <= '0;
            stop_q    <= 1'b0;
            expired_q <= 1'b0;
        end else if (load) begin
            count_q   <= load_val;
            reload_q  <= load_val;
            pcnt_q    <= '0;
            expired_q <= 1'b0;
            stop_q    <= load_val == '0;
            state_q   <= load_val == '0 ? DONE : RUN;
        end else begin
            expired_q <= 1'b0;
            if (adv)
                pcnt_q <= tick ? '0 : pcnt_q + PW'(1);
            if (tick) begin
                if (count_q > W'(1)) begin
                    count_q <= count_q - W'(1);
                end else if (auto_reload) begin
                    count_q   <= reload_q;
                    expired_q <= 1'b1;
                end else begin
                    // One-shot expiry: freeze at zero until load or reset
                    count_q   <= '0;
                    stop_q    <= 1'b1;
                    expired_q <= 1'b1;
                    state_q   <= DONE;
                end
            end
        end
    end
    assign count   = count_q;
    assign stop    = stop_q;
    assign expired = expired_q;
    assign running = state_q == RUN;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed scoreboard bench for a PRESCALE=1 and a PRESCALE=3 timer.
module tb_countdown_timer;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic       rst_a = 1'b0, en_a = 1'b0, ld_a = 1'b0, ar_a = 1'b0;
    logic [3:0] lv_a = '0;
    logic [3:0] cnt_a;
    logic       stop_a, exp_a, run_a;
    logic       rst_b = 1'b0, en_b = 1'b0, ld_b = 1'b0, ar_b = 1'b0;
    logic [3:0] lv_b = '0;
    logic [3:0] cnt_b;
    logic       stop_b, exp_b, run_b;
    countdown_timer #(.W(4), .DEFAULT_LOAD(9), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .load(ld_a), .load_val(lv_a), .auto_reload(ar_a),
        .count(cnt_a), .stop(stop_a), .expired(exp_a), .running(run_a));
    countdown_timer #(.W(4), .DEFAULT_LOAD(9), .PRESCALE(3)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .load(ld_b), .load_val(lv_b), .auto_reload(ar_b),
        .count(cnt_b), .stop(stop_b), .expired(exp_b), .running(run_b));
    typedef struct {
        string      tag;
        int         d;
        logic [6:0] v;
    } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;
    function automatic void expect_v(string t, int d, int c, bit s, bit e, bit r);
        q.push_back('{t, d, {4'(c), s, e, r}});
    endfunction
    task automatic cyc();
        exp_t       x;
        logic [6:0] a;
        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            x = q.pop_front();
            a = x.d == 0 ? {cnt_a, stop_a, exp_a, run_a} : {cnt_b, stop_b, exp_b, run_b};
            checks++;
            assert (a === x.v) else begin
                errors++;
                $error("FAIL %s: got count=%0d stop=%b expired=%b running=%b, need count=%0d stop=%b expired=%b running=%b",
                       x.tag, a[6:3], a[2], a[1], a[0], x.v[6:3], x.v[2], x.v[1], x.v[0]);
            end
        end
    endtask
    initial begin
        expect_v("a_reset", 0, 9, 0, 0, 1);
        expect_v("b_reset", 1, 9, 0, 0, 1);
        cyc();
        rst_a = 1'b1; en_a = 1'b1;
        for (int i = 8; i >= 0; i--) begin
            expect_v("a_oneshot", 0, i, i == 0, i == 0, i != 0);
            cyc();
        end
        expect_v("a_done_hold", 0, 0, 1, 0, 0);
        cyc();
        ar_a = 1'b1;
        expect_v("a_done_autoreload", 0, 0, 1, 0, 0);
        cyc();
        ar_a = 1'b0; rst_a = 1'b0;
        expect_v("a_reset_in_done", 0, 9, 0, 0, 1);
        cyc();
        rst_a = 1'b1;
        for (int i = 8; i >= 4; i--) begin
            expect_v("a_count_to_4", 0, i, 0, 0, 1);
            cyc();
        end
        rst_a = 1'b0;
        expect_v("a_reset_mid", 0, 9, 0, 0, 1);
        cyc();
        rst_a = 1'b1;
        expect_v("a_after_reset", 0, 8, 0, 0, 1);
        cyc();
        ld_a = 1'b1; lv_a = 4'd3; ar_a = 1'b1;
        expect_v("a_load3", 0, 3, 0, 0, 1);
        cyc();
        ld_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            expect_v("a_periodic", 0, 2 - (i % 3) == 2 ? 2 : (i % 3 == 1 ? 1 : 3), 0, i % 3 == 2, 1);
            cyc();
        end
        expect_v("a_periodic_2", 0, 2, 0, 0, 1);
        cyc();
        expect_v("a_periodic_1", 0, 1, 0, 0, 1);
        cyc();
        ld_a = 1'b1; lv_a = 4'd5; ar_a = 1'b0;
        expect_v("a_load_over_tick", 0, 5, 0, 0, 1);
        cyc();
        ld_a = 1'b0; en_a = 1'b0;
        expect_v("a_en_off_1", 0, 5, 0, 0, 1);
        cyc();
        expect_v("a_en_off_2", 0, 5, 0, 0, 1);
        cyc();
        en_a = 1'b1;
        expect_v("a_en_on", 0, 4, 0, 0, 1);
        cyc();
        ld_a = 1'b1; lv_a = 4'd0;
        expect_v("a_load0", 0, 0, 1, 0, 0);
        cyc();
        ld_a = 1'b0;
        expect_v("a_load0_hold", 0, 0, 1, 0, 0);
        cyc();
        ld_a = 1'b1; lv_a = 4'd2;
        expect_v("a_load2", 0, 2, 0, 0, 1);
        cyc();
        ld_a = 1'b0;
        expect_v("a_load2_1", 0, 1, 0, 0, 1);
        cyc();
        expect_v("a_load2_expire", 0, 0, 1, 1, 0);
        cyc();
        expect_v("a_expire_pulse_end", 0, 0, 1, 0, 0);
        cyc();
        ld_a = 1'b1; lv_a = 4'd7; rst_a = 1'b0;
        expect_v("a_reset_over_load", 0, 9, 0, 0, 1);
        cyc();
        ld_a = 1'b0; rst_a = 1'b1;
        expect_v("a_post_reset", 0, 8, 0, 0, 1);
        cyc();
        rst_b = 1'b1; en_b = 1'b1;
        expect_v("b_pre_1", 1, 9, 0, 0, 1); cyc();
        expect_v("b_pre_2", 1, 9, 0, 0, 1); cyc();
        expect_v("b_pre_tick", 1, 8, 0, 0, 1); cyc();
        expect_v("b_pre_4", 1, 8, 0, 0, 1); cyc();
        expect_v("b_pre_5", 1, 8, 0, 0, 1); cyc();
        expect_v("b_pre_tick2", 1, 7, 0, 0, 1); cyc();
        expect_v("b_pcnt1", 1, 7, 0, 0, 1); cyc();
        en_b = 1'b0;
        expect_v("b_gap_1", 1, 7, 0, 0, 1); cyc();
        expect_v("b_gap_2", 1, 7, 0, 0, 1); cyc();
        en_b = 1'b1;
        expect_v("b_pcnt2", 1, 7, 0, 0, 1); cyc();
        expect_v("b_delayed_tick", 1, 6, 0, 0, 1); cyc();
        expect_v("b_pcnt1_again", 1, 6, 0, 0, 1); cyc();
        rst_b = 1'b0;
        expect_v("b_reset_mid", 1, 9, 0, 0, 1); cyc();
        rst_b = 1'b1;
        expect_v("b_restart_1", 1, 9, 0, 0, 1); cyc();
        expect_v("b_restart_2", 1, 9, 0, 0, 1); cyc();
        ld_b = 1'b1; lv_b = 4'd2;
        expect_v("b_load2", 1, 2, 0, 0, 1); cyc();
        ld_b = 1'b0;
        expect_v("b_load_pcnt_1", 1, 2, 0, 0, 1); cyc();
        expect_v("b_load_pcnt_2", 1, 2, 0, 0, 1); cyc();
        expect_v("b_load_tick", 1, 1, 0, 0, 1); cyc();
        expect_v("b_wait_1", 1, 1, 0, 0, 1); cyc();
        expect_v("b_wait_2", 1, 1, 0, 0, 1); cyc();
        expect_v("b_expire", 1, 0, 1, 1, 0); cyc();
        expect_v("b_done", 1, 0, 1, 0, 0); cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
